eth_tx_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter that shares the MAC TX byte stream between NUM_PORTS

---
 rtl/eth_tx_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arbiter.sv
// Packet-granular round-robin arbiter in front of the MAC TX byte stream.
// Never interleaves packets; stalled or oversize source packets become tuser aborts.
module eth_tx_arbiter #(
  parameter int unsigned NUM_PORTS     = 2,
  parameter int unsigned MAX_BYTES     = 1514,
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic                   tx_clk,
  input  logic                   rst,
  input  logic [8*NUM_PORTS-1:0] s_tdata,
  input  logic [NUM_PORTS-1:0]   s_tlast,
  input  logic [NUM_PORTS-1:0]   s_tuser,
  input  logic [NUM_PORTS-1:0]   s_tvalid,
  output logic [NUM_PORTS-1:0]   s_tready,
  output logic [7:0]             m_tdata,
  output logic                   m_tlast,
  output logic                   m_tuser,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [NUM_PORTS-1:0]   grant,
  output logic                   pkt_done,
  output logic [15:0]            abort_count
);

  localparam int unsigned PW  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned BCW = 11;
  localparam int unsigned SCW = 16;
  localparam int unsigned ACW = 16;
  localparam logic [BCW-1:0] BYTE_LAST  = BCW'(MAX_BYTES - 1);
  localparam logic [SCW-1:0] STALL_LAST = SCW'(STALL_TIMEOUT - 1);
  localparam logic [PW:0]    PORTS_EXT  = (PW+1)'(NUM_PORTS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS,
    ST_ABORT,
    ST_DRAIN
  } state_t;

  state_t               state, state_nxt;
  logic [PW-1:0]        gidx, gidx_nxt;
  logic [PW-1:0]        rr_ptr, rr_ptr_nxt;
  logic [NUM_PORTS-1:0] grant_nxt;
  logic [BCW-1:0]       byte_cnt, byte_cnt_nxt;
  logic [SCW-1:0]       stall_cnt, stall_cnt_nxt;
  logic [ACW-1:0]       abort_count_nxt;
  logic                 pkt_done_nxt;
  logic                 abort_inc;

  logic [7:0]           g_tdata;
  logic                 g_tlast, g_tuser, g_tvalid;
  logic                 pick_valid;
  logic [PW-1:0]        pick_idx;
  logic [PW:0]          cand;
  logic [PW:0]          rr_inc;
  logic                 oversize;

  assign g_tdata  = s_tdata[{gidx, 3'b000} +: 8];
  assign g_tlast  = s_tlast[gidx];
  assign g_tuser  = s_tuser[gidx];
  assign g_tvalid = s_tvalid[gidx];
  assign oversize = (byte_cnt == BYTE_LAST) && !g_tlast;

  // Round-robin scan starting at rr_ptr, wrapping modulo NUM_PORTS.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, rr_ptr} + (PW+1)'(k);
      if (cand >= PORTS_EXT) cand = cand - PORTS_EXT;
      if (!pick_valid && s_tvalid[cand[PW-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand[PW-1:0];
      end
    end
    rr_inc = {1'b0, pick_idx} + (PW+1)'(1);
    if (rr_inc >= PORTS_EXT) rr_inc = '0;
  end

  always_comb begin
    state_nxt     = state;
    gidx_nxt      = gidx;
    grant_nxt     = grant;
    rr_ptr_nxt    = rr_ptr;
    byte_cnt_nxt  = byte_cnt;
    stall_cnt_nxt = stall_cnt;
    pkt_done_nxt  = 1'b0;
    abort_inc     = 1'b0;
    m_tdata       = '0;
    m_tlast       = 1'b0;
    m_tuser       = 1'b0;
    m_tvalid      = 1'b0;
    s_tready      = '0;

    case (state)
      ST_IDLE: begin
        if (pick_valid) begin
          gidx_nxt      = pick_idx;
          grant_nxt     = NUM_PORTS'(1) << pick_idx;
          rr_ptr_nxt    = rr_inc[PW-1:0];
          byte_cnt_nxt  = '0;
          stall_cnt_nxt = '0;
          state_nxt     = ST_PASS;
        end
      end

      ST_PASS: begin
        m_tdata  = g_tdata;
        m_tlast  = g_tlast;
        m_tuser  = g_tuser;
        m_tvalid = g_tvalid;
        s_tready = grant & {NUM_PORTS{m_tready}};
        // The beat that would exceed the frame limit is turned into the abort beat.
        if (g_tvalid && oversize) begin
          m_tlast = 1'b1;
          m_tuser = 1'b1;
        end
        if (g_tvalid) begin
          if (m_tready) begin
            byte_cnt_nxt  = byte_cnt + BCW'(1);
            stall_cnt_nxt = '0;
            if (g_tlast) begin
              pkt_done_nxt = !g_tuser;
              grant_nxt    = '0;
              state_nxt    = ST_IDLE;
            end else if (oversize) begin
              abort_inc = 1'b1;
              state_nxt = ST_DRAIN;
            end else if (g_tuser) begin
              state_nxt = ST_DRAIN;
            end
          end
        end else begin
          stall_cnt_nxt = stall_cnt + SCW'(1);
          if (stall_cnt == STALL_LAST) state_nxt = ST_ABORT;
        end
      end

      ST_ABORT: begin
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tuser  = 1'b1;
        if (m_tready) begin
          abort_inc = 1'b1;
          state_nxt = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        s_tready = grant;
        if (g_tvalid && g_tlast) begin
          grant_nxt = '0;
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        grant_nxt = '0;
        state_nxt = ST_IDLE;
      end
    endcase

    abort_count_nxt = abort_count;
    if (abort_inc && (abort_count != {ACW{1'b1}})) abort_count_nxt = abort_count + ACW'(1);
  end

  always_ff @(posedge tx_clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      gidx        <= '0;
      grant       <= '0;
      rr_ptr      <= '0;
      byte_cnt    <= '0;
      stall_cnt   <= '0;
      abort_count <= '0;
      pkt_done    <= 1'b0;
    end else begin
      state       <= state_nxt;
      gidx        <= gidx_nxt;
      grant       <= grant_nxt;
      rr_ptr      <= rr_ptr_nxt;
      byte_cnt    <= byte_cnt_nxt;
      stall_cnt   <= stall_cnt_nxt;
      abort_count <= abort_count_nxt;
      pkt_done    <= pkt_done_nxt;
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter: per-port source queues, expected MAC beats in a queue.
module tb_eth_tx_arbiter;

  localparam int unsigned NP = 2;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
    int         gap;
  } sbeat_t;

  typedef struct {
    logic [1:0] g;
    logic [7:0] d;
    logic       l;
    logic       u;
  } mbeat_t;

  logic        tx_clk = 1'b0;
  logic        rst    = 1'b1;
  logic [15:0] s_tdata;
  logic [1:0]  s_tlast, s_tuser, s_tvalid, s_tready;
  logic [7:0]  m_tdata;
  logic        m_tlast, m_tuser, m_tvalid;
  logic        m_tready = 1'b1;
  logic [1:0]  grant;
  logic        pkt_done;
  logic [15:0] abort_count;

  sbeat_t src_q[NP][$];
  mbeat_t exp_q[$];
  mbeat_t mon_e;
  int     n_tests = 0;
  int     n_fail  = 0;
  int     n_done  = 0;

  always #4 tx_clk = ~tx_clk;

  eth_tx_arbiter #(
    .NUM_PORTS    (2),
    .MAX_BYTES    (1514),
    .STALL_TIMEOUT(1024)
  ) dut (
    .tx_clk     (tx_clk),
    .rst        (rst),
    .s_tdata    (s_tdata),
    .s_tlast    (s_tlast),
    .s_tuser    (s_tuser),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .m_tuser    (m_tuser),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .grant      (grant),
    .pkt_done   (pkt_done),
    .abort_count(abort_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Source drivers: each head beat waits 'gap' idle cycles, then is held until accepted.
  for (genvar p = 0; p < NP; p++) begin : g_drv
    logic [7:0] dd;
    logic       dl, du, dv;
    int         gap_left;
    bit         acc;
    bit         head_new;
    initial begin
      dd = '0; dl = 1'b0; du = 1'b0; dv = 1'b0;
      gap_left = 0; acc = 1'b0; head_new = 1'b1;
      forever begin
        @(posedge tx_clk); #1;
        if (acc && src_q[p].size() > 0) begin
          void'(src_q[p].pop_front());
          head_new = 1'b1;
        end
        if (src_q[p].size() == 0) begin
          dv = 1'b0; dl = 1'b0; du = 1'b0; head_new = 1'b1;
        end else begin
          if (head_new) begin
            gap_left = src_q[p][0].gap;
            head_new = 1'b0;
          end
          if (gap_left > 0) begin
            gap_left--;
            dv = 1'b0;
          end else begin
            dv = 1'b1; dd = src_q[p][0].d; dl = src_q[p][0].l; du = src_q[p][0].u;
          end
        end
        @(negedge tx_clk);
        acc = dv && s_tready[p];
      end
    end
  end

  assign s_tdata  = {g_drv[1].dd, g_drv[0].dd};
  assign s_tlast  = {g_drv[1].dl, g_drv[0].dl};
  assign s_tuser  = {g_drv[1].du, g_drv[0].du};
  assign s_tvalid = {g_drv[1].dv, g_drv[0].dv};

  // Output monitor: every MAC transfer must match the next expected beat.
  always @(negedge tx_clk) begin
    if (!rst) begin
      if (pkt_done) n_done++;
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          check("sb_extra_beat", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat", 32'({grant, m_tdata, m_tlast, m_tuser}),
                32'({mon_e.g, mon_e.d, mon_e.l, mon_e.u}));
        end
      end
    end
  end

  initial begin
    #(8 * 60000);
    $display("FAIL watchdog: simulation exceeded 60000 cycles");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge tx_clk); #1;
  endtask

  task automatic push_src(input int p, input logic [7:0] d, input logic l, input logic u,
                          input int gap);
    sbeat_t b;
    b.d = d; b.l = l; b.u = u; b.gap = gap;
    src_q[p].push_back(b);
  endtask

  task automatic push_exp(input int p, input logic [7:0] d, input logic l, input logic u);
    mbeat_t e;
    e.g = 2'(1 << p); e.d = d; e.l = l; e.u = u;
    exp_q.push_back(e);
  endtask

  task automatic send_pkt(input int p, input int len, input logic u_last);
    logic [7:0] d;
    logic       l;
    for (int i = 0; i < len; i++) begin
      d = 8'($urandom);
      l = (i == len - 1);
      push_src(p, d, l, l & u_last, 0);
      push_exp(p, d, l, l & u_last);
    end
  endtask

  task automatic flush_all();
    src_q[0].delete();
    src_q[1].delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_tready = 1'b1;
    flush_all();
    repeat (3) tick();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    check("rst_abort_count", 32'(abort_count), 32'd0);
    check("rst_pkt_done", 32'(pkt_done), 32'd0);
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    bit ok;
    n = 0;
    while ((exp_q.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0 ||
            grant != 2'b00) && n < budget) begin
      tick();
      n++;
    end
    ok = (n < budget);
    check({tag, "_timeout"}, 32'(ok), 32'd1);
    if (!ok) flush_all();
    repeat (2) tick();
    check({tag, "_idle_grant"}, 32'(grant), 32'd0);
  endtask

  task automatic wait_grant(input string tag, input logic [1:0] want, input int budget);
    int n;
    bit ok;
    n = 0;
    while (grant != want && n < budget) begin
      tick();
      n++;
    end
    ok = (n < budget);
    check({tag, "_grant_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_exp_le(input string tag, input int lim, input int budget);
    int n;
    bit ok;
    n = 0;
    while (exp_q.size() > lim && n < budget) begin
      tick();
      n++;
    end
    ok = (n < budget);
    check({tag, "_progress_timeout"}, 32'(ok), 32'd1);
  endtask

  initial begin
    int         d0;
    int         n;
    logic [7:0] d;
    tick();

    // 1: single 64-byte packet, grant one cycle after tvalid
    do_reset();
    d0 = n_done;
    send_pkt(0, 64, 1'b0);
    n = 0;
    do begin
      @(negedge tx_clk);
      n++;
    end while (!s_tvalid[0] && n < 20);
    check("t1_grant_before_arb", 32'(grant), 32'd0);
    @(negedge tx_clk);
    check("t1_grant_after_arb", 32'(grant), 32'd1);
    wait_idle("t1", 300);
    check("t1_pkt_done", 32'(n_done - d0), 32'd1);
    check("t1_abort_count", 32'(abort_count), 32'd0);

    // 2: both ports with three packets each alternate without interleaving
    do_reset();
    d0 = n_done;
    for (int k = 0; k < 3; k++) begin
      send_pkt(0, 20, 1'b0);
      send_pkt(1, 20, 1'b0);
    end
    wait_idle("t2", 500);
    check("t2_pkt_done", 32'(n_done - d0), 32'd6);
    check("t2_abort_count", 32'(abort_count), 32'd0);

    // 3: P1 stalls 1100 cycles after beat 10 -> abort beat, drain, then P0
    do_reset();
    d0 = n_done;
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      if (i < 10) begin
        push_src(1, d, 1'b0, 1'b0, 0);
        push_exp(1, d, 1'b0, 1'b0);
      end else if (i == 10) begin
        push_src(1, d, 1'b0, 1'b0, 1100);
        push_exp(1, 8'h00, 1'b1, 1'b1);
      end else begin
        push_src(1, d, (i == 19), 1'b0, 0);
      end
    end
    wait_grant("t3", 2'b10, 20);
    send_pkt(0, 16, 1'b0);
    wait_idle("t3", 3000);
    check("t3_abort_count", 32'(abort_count), 32'd1);
    check("t3_pkt_done", 32'(n_done - d0), 32'd1);

    // 4: 1600-beat packet -> beat 1514 forced tlast/tuser, remainder drained
    do_reset();
    d0 = n_done;
    for (int i = 0; i < 1600; i++) begin
      d = 8'($urandom);
      push_src(0, d, (i == 1599), 1'b0, 0);
      if (i < 1513) push_exp(0, d, 1'b0, 1'b0);
      else if (i == 1513) push_exp(0, d, 1'b1, 1'b1);
    end
    wait_idle("t4", 2500);
    check("t4_abort_count", 32'(abort_count), 32'd1);
    check("t4_pkt_done", 32'(n_done - d0), 32'd0);

    // 5: long MAC backpressure mid-packet is not a stall
    do_reset();
    d0 = n_done;
    send_pkt(0, 40, 1'b0);
    wait_exp_le("t5", 20, 200);
    m_tready = 1'b0;
    repeat (5000) tick();
    check("t5_hold_m_tvalid", 32'(m_tvalid), 32'd1);
    check("t5_hold_grant", 32'(grant), 32'd1);
    check("t5_hold_abort", 32'(abort_count), 32'd0);
    m_tready = 1'b1;
    wait_idle("t5", 300);
    check("t5_abort_count", 32'(abort_count), 32'd0);
    check("t5_pkt_done", 32'(n_done - d0), 32'd1);

    // 6: reset mid-packet clears at once; next arbitration restarts at port 0
    do_reset();
    send_pkt(0, 50, 1'b0);
    wait_exp_le("t6", 30, 200);
    rst = 1'b1;
    #1;
    check("t6_rst_grant", 32'(grant), 32'd0);
    check("t6_rst_m_tvalid", 32'(m_tvalid), 32'd0);
    flush_all();
    repeat (3) tick();
    rst = 1'b0;
    tick();
    d0 = n_done;
    send_pkt(0, 8, 1'b0);
    send_pkt(1, 8, 1'b0);
    wait_idle("t6", 300);
    check("t6_pkt_done", 32'(n_done - d0), 32'd2);

    // 7: source-flagged abort gives no pkt_done; exact max-length packet ends cleanly
    do_reset();
    d0 = n_done;
    send_pkt(1, 10, 1'b1);
    wait_idle("t7a", 200);
    check("t7_src_abort_pkt_done", 32'(n_done - d0), 32'd0);
    check("t7_src_abort_count", 32'(abort_count), 32'd0);
    d0 = n_done;
    send_pkt(0, 1514, 1'b0);
    wait_idle("t7b", 2000);
    check("t7_max_len_pkt_done", 32'(n_done - d0), 32'd1);
    check("t7_max_len_abort", 32'(abort_count), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
